// File: rtl/l2_line_responder.sv
// L2-side responder for the L1 cacheline request/response interface: accepts a held
// line read or write, serves it from a small line store after LATENCY cycles, and pulses L2_resp.
module l2_line_responder #(
  parameter int DEPTH   = 16,
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         L2_read,
  input  logic         L2_write,
  input  logic [31:0]  L2_addr,
  input  logic [255:0] L2_wdata,
  output logic         L2_resp,
  output logic [255:0] L2_rdata,
  output logic         proto_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               op_wr_r;
  logic [IDX_W-1:0]   idx_r;
  logic [255:0]       wdata_r;
  logic               resp_r;
  logic [255:0]       rdata_r;
  logic               proto_err_r;
  logic [255:0]       mem_r [DEPTH];

  logic               req_s;
  logic               accept_s;
  logic [IDX_W-1:0]   idx_in_s;
  logic               cmt_en_s;
  logic               cmt_wr_s;
  logic [IDX_W-1:0]   cmt_idx_s;
  logic [255:0]       cmt_wdata_s;
  logic               unused_addr_s;

  assign req_s         = L2_read | L2_write;
  assign accept_s      = (state_r == ST_IDLE) && req_s;
  assign idx_in_s      = L2_addr[5 +: IDX_W];
  assign unused_addr_s = ^{L2_addr[31:5+IDX_W], L2_addr[4:0]};

  // State register with latency counter and captured request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      op_wr_r <= 1'b0;
      idx_r   <= '0;
      wdata_r <= '0;
    end else begin
      state_r <= next_state_s;
      if (accept_s) begin
        cnt_r   <= CNT_INIT;
        op_wr_r <= L2_write;
        idx_r   <= idx_in_s;
        wdata_r <= L2_wdata;
      end else if (state_r == ST_BUSY) begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end
  end

  // Next-state logic; a full request drop in BUSY aborts ahead of completion.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          next_state_s = (LATENCY == 1) ? ST_RESP : ST_BUSY;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!req_s) begin
          next_state_s = ST_IDLE;
        end else if (cnt_r == CNT_ONE) begin
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_BUSY;
        end
      end
      ST_RESP: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Commit controls; with LATENCY==1 the commit comes straight from the live inputs.
  always_comb begin
    cmt_en_s    = 1'b0;
    cmt_wr_s    = 1'b0;
    cmt_idx_s   = '0;
    cmt_wdata_s = '0;
    if (next_state_s == ST_RESP) begin
      cmt_en_s = 1'b1;
      if (state_r == ST_IDLE) begin
        cmt_wr_s    = L2_write;
        cmt_idx_s   = idx_in_s;
        cmt_wdata_s = L2_wdata;
      end else begin
        cmt_wr_s    = op_wr_r;
        cmt_idx_s   = idx_r;
        cmt_wdata_s = wdata_r;
      end
    end else begin
      cmt_en_s = 1'b0;
    end
  end

  // Registered response pulse, read data and sticky protocol error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_r      <= 1'b0;
      rdata_r     <= '0;
      proto_err_r <= 1'b0;
    end else begin
      resp_r <= cmt_en_s;
      if (cmt_en_s && !cmt_wr_s) begin
        rdata_r <= mem_r[cmt_idx_s];
      end
      if (accept_s && L2_read && L2_write) begin
        proto_err_r <= 1'b1;
      end
    end
  end

  // Line store: not reset, and never written while reset is held.
  always_ff @(posedge clk) begin
    if (!rst && cmt_en_s && cmt_wr_s) begin
      mem_r[cmt_idx_s] <= cmt_wdata_s;
    end
  end

  assign L2_resp   = resp_r;
  assign L2_rdata  = rdata_r;
  assign proto_err = proto_err_r;

endmodule

// File: tb/tb_l2_line_responder.sv
// Scoreboard bench for l2_line_responder: a LATENCY=4 instance and a LATENCY=1 instance,
// directed requests push expected responses that negedge monitors pop and compare.
module tb_l2_line_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         a_read = 1'b0, a_write = 1'b0, b_read = 1'b0, b_write = 1'b0;
  logic [31:0]  a_addr = '0, b_addr = '0;
  logic [255:0] a_wdata = '0, b_wdata = '0;
  logic         a_resp, b_resp, a_perr, b_perr;
  logic [255:0] a_rdata, b_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    string        name;
    int           cyc;
    logic [255:0] rdata;
    logic         perr;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  localparam logic [255:0] D_A5 = {8{32'hA5A5A5A5}};
  localparam logic [255:0] D_5A = {8{32'h5A5A5A5A}};
  localparam logic [255:0] D_3C = {8{32'h3C3C3C3C}};
  localparam logic [255:0] D_FF = {8{32'hFFFFFFFF}};
  localparam logic [255:0] D_22 = {8{32'h22222222}};
  localparam logic [255:0] D_33 = {8{32'h33333333}};
  localparam logic [255:0] D_77 = {8{32'h77777777}};
  localparam logic [255:0] D_00 = 256'h0;

  l2_line_responder #(.DEPTH(16), .LATENCY(4)) dut_a (
    .clk(clk), .rst(rst), .L2_read(a_read), .L2_write(a_write), .L2_addr(a_addr),
    .L2_wdata(a_wdata), .L2_resp(a_resp), .L2_rdata(a_rdata), .proto_err(a_perr)
  );

  l2_line_responder #(.DEPTH(16), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .L2_read(b_read), .L2_write(b_write), .L2_addr(b_addr),
    .L2_wdata(b_wdata), .L2_resp(b_resp), .L2_rdata(b_rdata), .proto_err(b_perr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check1(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare(input string tag, input exp_t e, input logic [255:0] rd, input logic pe);
    check1({tag, " ", e.name, " resp_cycle"}, 256'(cyc), 256'(e.cyc));
    check1({tag, " ", e.name, " rdata"}, rd, e.rdata);
    check1({tag, " ", e.name, " proto_err"}, 256'(pe), 256'(e.perr));
  endtask

  // Monitors: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && a_resp) begin
      if (qa.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_unexpected_resp: got resp=1 expected none at cycle %0d", cyc);
      end else begin
        compare("A", qa.pop_front(), a_rdata, a_perr);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_resp) begin
      if (qb.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected_resp: got resp=1 expected none at cycle %0d", cyc);
      end else begin
        compare("B", qb.pop_front(), b_rdata, b_perr);
      end
    end
  end

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [255:0] wd);
    if (sel == 0) begin
      a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd;
    end else begin
      b_read = rd; b_write = wr; b_addr = addr; b_wdata = wd;
    end
  endtask

  // Issue one request, expect its response, hold until the response, then drop.
  task automatic req(input int sel, input string name, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [255:0] wd,
                     input logic [255:0] exp_rd, input logic exp_perr);
    exp_t e;
    int   lat;
    logic seen;
    lat = (sel == 0) ? 4 : 1;
    @(negedge clk);
    drive(sel, rd, wr, addr, wd);
    e.name = name; e.cyc = cyc + lat; e.rdata = exp_rd; e.perr = exp_perr;
    if (sel == 0) qa.push_back(e); else qb.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < lat + 6 && !seen; i++) begin
      @(negedge clk);
      seen = (sel == 0) ? a_resp : b_resp;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s timeout: got no resp expected resp within %0d cycles", name, lat + 6);
    end
    drive(sel, 1'b0, 1'b0, 32'h0, D_00);
    @(negedge clk);
    check1({name, " resp_width"}, 256'((sel == 0) ? a_resp : b_resp), 256'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check1("reset resp", 256'(a_resp), 256'h0);
    check1("reset rdata", a_rdata, D_00);
    check1("reset proto_err", 256'(a_perr), 256'h0);
    rst = 1'b0;

    req(0, "seed_w_c0", 1'b0, 1'b1, 32'h0000_00C0, D_5A, D_00, 1'b0);
    req(0, "w_40", 1'b0, 1'b1, 32'h0000_0040, D_A5, D_00, 1'b0);
    req(0, "r_40", 1'b1, 1'b0, 32'h0000_0040, D_00, D_A5, 1'b0);
    req(0, "r_5f", 1'b1, 1'b0, 32'h0000_005F, D_00, D_A5, 1'b0);
    req(0, "rw_80", 1'b1, 1'b1, 32'h0000_0080, D_3C, D_A5, 1'b1);
    req(0, "r_80", 1'b1, 1'b0, 32'h0000_0080, D_00, D_3C, 1'b1);

    // Write to 0xC0 abandoned on the edge that would otherwise complete it.
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h0000_00C0, D_FF);
    repeat (3) @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, D_00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check1("abort no_resp", 256'(a_resp), 256'h0);
    end
    check1("abort proto_err sticky", 256'(a_perr), 256'h1);
    req(0, "r_c0_after_abort", 1'b1, 1'b0, 32'h0000_00C0, D_00, D_5A, 1'b1);

    // Reset in the middle of a write must clear outputs at once and skip the commit.
    req(0, "w_100", 1'b0, 1'b1, 32'h0000_0100, D_22, D_5A, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h0000_0100, D_33);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check1("midrst resp", 256'(a_resp), 256'h0);
    check1("midrst rdata", a_rdata, D_00);
    check1("midrst proto_err", 256'(a_perr), 256'h0);
    drive(0, 1'b0, 1'b0, 32'h0, D_00);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check1("postrst no_resp", 256'(a_resp), 256'h0);
    end
    req(0, "r_100_no_commit", 1'b1, 1'b0, 32'h0000_0100, D_00, D_22, 1'b0);

    req(1, "b_w_0", 1'b0, 1'b1, 32'h0000_0000, D_77, D_00, 1'b0);
    req(1, "b_r_400_alias", 1'b1, 1'b0, 32'h0000_0400, D_00, D_77, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d/%0d outstanding expected 0/0", qa.size(), qb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
